// File: rtl/fp_regfile_scoreboard.sv
// Floating-point register file with a per-register pending-write scoreboard.
// After reset the file sweeps every register to zero (INIT) before it
// accepts traffic (RUN). Reads are combinational, with optional same-cycle
// forwarding of the write-back port. Addresses at or beyond NUM_REGS are
// inert: they are never written or marked, and they read as zero and not busy.
module fp_regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] fds3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] frs1,
  output logic [DATA_W-1:0] frs2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              busy1,
  output logic              busy2,
  output logic              ready
);

  // Storage spans the full address space so any address can index the
  // arrays; entries at or above NUM_REGS are never written or read.
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   NREGS = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic                ready_q, ready_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  // Next-state logic: INIT walks init_cnt across the file, then RUN forever.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = ready_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = INIT;
        ready_d = 1'b0;
      end
    endcase
  end

  // Next data and scoreboard contents; a same-cycle issue overrides the clear.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (state_q == INIT) begin
      mem_d[init_cnt_q] = '0;
    end else begin
      if (we3 && in_range(a3)) begin
        mem_d[a3]  = fds3;
        busy_d[a3] = 1'b0;
      end
      if (iss_valid && in_range(iss_rd)) begin
        busy_d[iss_rd] = 1'b1;
      end
    end
  end

  // Control state, asynchronously cleared; busy bits count as control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // Register contents carry no reset; the INIT sweep zeroes them instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read ports: gated to zero outside RUN, which also covers reset at once.
  always_comb begin
    frs1  = '0;
    frs2  = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (state_q == RUN) begin
      if (in_range(a1)) begin
        frs1  = mem_q[a1];
        busy1 = busy_q[a1];
        if ((BYPASS != 0) && we3 && (a3 == a1)) begin
          frs1  = fds3;
          busy1 = 1'b0;
        end
      end
      if (in_range(a2)) begin
        frs2  = mem_q[a2];
        busy2 = busy_q[a2];
        if ((BYPASS != 0) && we3 && (a3 == a2)) begin
          frs2  = fds3;
          busy2 = 1'b0;
        end
      end
    end
  end

  assign ready = ready_q;

endmodule
